// File: rtl/shift_extend_unit.sv
// Multi-cycle shift/extend unit: SLL/SRL/SRA executed STEP bits per cycle,
// byte/half zero/sign extension and pass-through completed in a single cycle.
module shift_extend_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           src,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           result
);

    localparam int SHAMT_W = $clog2(WIDTH);
    // One extra bit so that STEP == WIDTH is representable in the step comparison.
    localparam int CNT_W   = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    localparam logic [2:0] OP_SLL    = 3'd0;
    localparam logic [2:0] OP_SRL    = 3'd1;
    localparam logic [2:0] OP_SRA    = 3'd2;
    localparam logic [2:0] OP_ZEXT_H = 3'd3;
    localparam logic [2:0] OP_SEXT_H = 3'd4;
    localparam logic [2:0] OP_ZEXT_B = 3'd5;
    localparam logic [2:0] OP_SEXT_B = 3'd6;
    localparam logic [2:0] OP_PASS   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, done_q;

    logic               accept_s;
    logic [CNT_W-1:0]   step_amt_s;
    logic [WIDTH-1:0]   shifted_s;

    function automatic logic [WIDTH-1:0] ext_fn(input logic [2:0] o, input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        case (o)
            OP_ZEXT_H: r = {{(WIDTH-16){1'b0}}, s[15:0]};
            OP_SEXT_H: r = {{(WIDTH-16){s[15]}}, s[15:0]};
            OP_ZEXT_B: r = {{(WIDTH-8){1'b0}}, s[7:0]};
            OP_SEXT_B: r = {{(WIDTH-8){s[7]}}, s[7:0]};
            OP_PASS:   r = s;
            default:   r = s;   // shift ops with a zero amount
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] shift_fn(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                                  input logic [CNT_W-1:0] amt);
        logic [WIDTH-1:0] r;
        case (o)
            OP_SLL:  r = a << amt;
            OP_SRL:  r = a >> amt;
            OP_SRA:  r = $signed(a) >>> amt;
            default: r = a;
        endcase
        return r;
    endfunction

    assign accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Per-cycle shift amount min(STEP, cnt) and the resulting accumulator value.
    always_comb begin
        step_amt_s = STEP_C;
        if (cnt_q <= STEP_C) begin
            step_amt_s = cnt_q;
        end else begin
            step_amt_s = STEP_C;
        end
        shifted_s = shift_fn(op_q, acc_q, step_amt_s);
    end

    // Next-state logic for the FSM and datapath registers.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    op_d = op;
                    if ((op <= OP_SRA) && (shamt != {SHAMT_W{1'b0}})) begin
                        acc_d   = src;
                        cnt_d   = {1'b0, shamt};
                        state_d = ST_SHIFT;
                    end else begin
                        result_d = ext_fn(op, src);
                        state_d  = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = shifted_s;
                cnt_d = cnt_q - step_amt_s;
                if (cnt_q <= STEP_C) begin
                    result_d = shifted_s;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'd0;
            acc_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            result_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= (state_d == ST_SHIFT);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_extend_unit.sv
// Directed bench: STEP=1 instance (a) and STEP=4 instance (b) share operands, separate starts.
module tb_shift_extend_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] result_a, result_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_extend_unit #(.WIDTH(32), .STEP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .op(op), .src(src), .shamt(shamt),
        .busy(busy_a), .done(done_a), .result(result_a)
    );

    shift_extend_unit #(.WIDTH(32), .STEP(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .op(op), .src(src), .shamt(shamt),
        .busy(busy_b), .done(done_b), .result(result_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then scramble the inputs and count cycles until done.
    task automatic run_op(input bit use_b, input logic [2:0] o, input logic [31:0] s,
                          input logic [4:0] sh, input int exp_cyc, input int exp_busy,
                          input logic [31:0] exp_res, input string tag);
        int cyc;
        int bcnt;
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        op = o; src = s; shamt = sh;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        op = ~o; src = ~s; shamt = ~sh;
        cyc = 1;
        bcnt = 0;
        while (!(use_b ? done_b : done_a) && cyc < 100) begin
            if (use_b ? busy_b : busy_a) bcnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, {31'd0, (use_b ? done_b : done_a)}, 32'd1);
        check({tag, "_cycle"}, cyc, exp_cyc);
        check({tag, "_busycnt"}, bcnt, exp_busy);
        check({tag, "_result"}, use_b ? result_b : result_a, exp_res);
        @(negedge clk);
        check({tag, "_donelow"}, {31'd0, (use_b ? done_b : done_a)}, 32'd0);
        check({tag, "_hold"}, use_b ? result_b : result_a, exp_res);
    endtask

    initial begin
        int dcnt;
        repeat (2) @(negedge clk);
        check("rst_busy_a", {31'd0, busy_a}, 32'd0);
        check("rst_done_a", {31'd0, done_a}, 32'd0);
        check("rst_result_a", result_a, 32'd0);
        check("rst_result_b", result_b, 32'd0);
        rst_n = 1'b1;

        run_op(1'b0, 3'd0, 32'h0000_0001, 5'd31, 32, 31, 32'h8000_0000, "sll31");
        run_op(1'b0, 3'd2, 32'h8000_0000, 5'd4, 5, 4, 32'hF800_0000, "sra4");
        run_op(1'b0, 3'd1, 32'h8000_0000, 5'd4, 5, 4, 32'h0800_0000, "srl4");
        run_op(1'b0, 3'd4, 32'h1234_8001, 5'd0, 1, 0, 32'hFFFF_8001, "sext_h");
        run_op(1'b0, 3'd3, 32'h1234_8001, 5'd9, 1, 0, 32'h0000_8001, "zext_h");
        run_op(1'b0, 3'd5, 32'h0000_00F0, 5'd0, 1, 0, 32'h0000_00F0, "zext_b");
        run_op(1'b0, 3'd6, 32'h0000_00F0, 5'd0, 1, 0, 32'hFFFF_FFF0, "sext_b");
        run_op(1'b0, 3'd7, 32'hDEAD_BEEF, 5'd3, 1, 0, 32'hDEAD_BEEF, "pass");
        run_op(1'b0, 3'd2, 32'h8000_0000, 5'd0, 1, 0, 32'h8000_0000, "sra0");

        run_op(1'b1, 3'd1, 32'hFFFF_FFFF, 5'd7, 3, 2, 32'h01FF_FFFF, "s4_srl7");
        run_op(1'b1, 3'd1, 32'hA5A5_A5A5, 5'd0, 1, 0, 32'hA5A5_A5A5, "s4_srl0");
        run_op(1'b1, 3'd0, 32'h0000_0001, 5'd8, 3, 2, 32'h0000_0100, "s4_sll8");
        run_op(1'b1, 3'd2, 32'h8000_0000, 5'd31, 9, 8, 32'hFFFF_FFFF, "s4_sra31");

        // Start during SHIFT is ignored; start in the DONE cycle is accepted.
        @(negedge clk);
        start_a = 1'b1; op = 3'd0; src = 32'h0000_0003; shamt = 5'd3;
        @(negedge clk);
        start_a = 1'b0;
        check("ign_busy1", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        start_a = 1'b1; op = 3'd1; src = 32'hFFFF_FFFF; shamt = 5'd1;
        @(negedge clk);
        start_a = 1'b0;
        check("ign_busy3", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        check("ign_done", {31'd0, done_a}, 32'd1);
        check("ign_result", result_a, 32'h0000_0018);
        start_a = 1'b1; op = 3'd4; src = 32'h0000_8000; shamt = 5'd0;
        @(negedge clk);
        start_a = 1'b0;
        check("b2b_done", {31'd0, done_a}, 32'd1);
        check("b2b_result", result_a, 32'hFFFF_8000);
        @(negedge clk);
        check("b2b_donelow", {31'd0, done_a}, 32'd0);

        // Reset mid-shift aborts the operation.
        @(negedge clk);
        start_a = 1'b1; op = 3'd0; src = 32'h0000_0001; shamt = 5'd20;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_pre", {31'd0, busy_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        check("abort_done", {31'd0, done_a}, 32'd0);
        check("abort_result", result_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done_a || busy_a) dcnt++;
        end
        check("abort_nodone", dcnt, 32'd0);
        check("abort_result_hold", result_a, 32'd0);
        run_op(1'b0, 3'd0, 32'h0000_0001, 5'd5, 6, 5, 32'h0000_0020, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
